// File: rtl/uut_test_sequencer_if.sv
// Bundle between the test sequencer and its surroundings: vector stream in,
// UUT drive/observe, result stream out.
interface uut_test_sequencer_if #(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = 88,
  parameter int CNT_WIDTH   = 32
);
  logic                   vec_valid;
  logic                   vec_ready;
  logic [INPUT_SIZE-1:0]  vec_input;
  logic [OUTPUT_SIZE-1:0] vec_expected;

  logic                   rst_uut;
  logic [INPUT_SIZE-1:0]  input_to_uut;
  logic                   end_uut;
  logic                   err_uut;
  logic [OUTPUT_SIZE-1:0] output_from_uut;

  logic                   res_valid;
  logic                   res_ready;
  logic [OUTPUT_SIZE-1:0] res_output;
  logic                   res_pass;
  logic                   res_err;
  logic                   res_timeout;
  logic [CNT_WIDTH-1:0]   res_cycles;
  logic                   busy;

  modport master (
    input  vec_valid, vec_input, vec_expected,
    input  end_uut, err_uut, output_from_uut,
    input  res_ready,
    output vec_ready, rst_uut, input_to_uut,
    output res_valid, res_output, res_pass, res_err, res_timeout, res_cycles, busy
  );

  modport slave (
    output vec_valid, vec_input, vec_expected,
    output end_uut, err_uut, output_from_uut,
    output res_ready,
    input  vec_ready, rst_uut, input_to_uut,
    input  res_valid, res_output, res_pass, res_err, res_timeout, res_cycles, busy
  );
endinterface

// File: rtl/uut_test_sequencer.sv
// Runs one test vector at a time on a UUT: reset it, release it, wait for
// done/error/timeout, then report captured output, pass flag and run length.
//
// state     | meaning
// IDLE      | UUT parked in reset, ready for a vector
// RESET_UUT | UUT held in reset for RST_CYCLES with new stimulus applied
// RUN       | UUT released, cycle counter running, watching end/err
// REPORT    | result presented, UUT parked again until consumer takes it
module uut_test_sequencer #(
  parameter int INPUT_SIZE     = 64,
  parameter int OUTPUT_SIZE    = 88,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 32
) (
  input logic                clk,
  input logic                rst,
  uut_test_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RESET_UUT, RUN, REPORT} state_t;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0]        RST_LOAD    = RW'(RST_CYCLES - 1);

  state_t                 state;
  logic [RW-1:0]          rst_cnt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [INPUT_SIZE-1:0]  input_q;
  logic [OUTPUT_SIZE-1:0] expected_q;
  logic [OUTPUT_SIZE-1:0] output_q;
  logic                   pass_q;
  logic                   err_q;
  logic                   timeout_q;
  logic [CNT_WIDTH-1:0]   cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      cnt        <= '0;
      input_q    <= '0;
      expected_q <= '0;
      output_q   <= '0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.vec_valid) begin
            input_q    <= bus.vec_input;
            expected_q <= bus.vec_expected;
            output_q   <= '0;
            pass_q     <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            cycles_q   <= '0;
            cnt        <= '0;
            rst_cnt    <= RST_LOAD;
            state      <= RESET_UUT;
          end
        end
        RESET_UUT: begin
          if (rst_cnt == '0) begin
            cnt   <= CNT_WIDTH'(1);
            state <= RUN;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        RUN: begin
          // end wins over err, and either wins over a coincident timeout
          if (bus.end_uut) begin
            output_q <= bus.output_from_uut;
            err_q    <= bus.err_uut;
            pass_q   <= !bus.err_uut && (bus.output_from_uut == expected_q);
            cycles_q <= cnt;
            state    <= REPORT;
          end else if (bus.err_uut) begin
            output_q <= bus.output_from_uut;
            err_q    <= 1'b1;
            pass_q   <= 1'b0;
            cycles_q <= cnt;
            state    <= REPORT;
          end else if (cnt == TIMEOUT_LIM) begin
            output_q  <= bus.output_from_uut;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            cycles_q  <= cnt;
            state     <= REPORT;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        REPORT: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.rst_uut      = (state != RUN);
  assign bus.res_valid    = (state == REPORT);
  assign bus.input_to_uut = input_q;
  assign bus.res_output   = output_q;
  assign bus.res_pass     = pass_q;
  assign bus.res_err      = err_q;
  assign bus.res_timeout  = timeout_q;
  assign bus.res_cycles   = cycles_q;

endmodule

// File: tb/tb_uut_test_sequencer.sv
// Directed bench for uut_test_sequencer with a counting UUT model whose
// end/err cycle is programmable per scenario.
module tb_uut_test_sequencer;

  localparam logic [63:0] V1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V2 = 64'hDEAD_BEEF_0000_1111;
  localparam logic [63:0] V3 = 64'h5A5A_A5A5_3C3C_C3C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   end_at = 0;
  int   err_at = 0;
  int   uk = 0;

  always #5 clk = ~clk;

  uut_test_sequencer_if #(.INPUT_SIZE(64), .OUTPUT_SIZE(88), .CNT_WIDTH(32)) ifc ();

  uut_test_sequencer #(
    .INPUT_SIZE(64), .OUTPUT_SIZE(88), .RST_CYCLES(4),
    .TIMEOUT_CYCLES(20), .CNT_WIDTH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  // UUT model: during the k-th cycle after reset release uk == k-1
  always @(posedge clk) uk <= ifc.rst_uut ? 0 : uk + 1;
  assign ifc.end_uut = !ifc.rst_uut && (end_at != 0) && (uk + 1 == end_at);
  assign ifc.err_uut = !ifc.rst_uut && (err_at != 0) && (uk + 1 == err_at);
  assign ifc.output_from_uut = {24'h0, ifc.input_to_uut};

  task automatic run_vec(input logic [63:0] vin, input logic [87:0] vexp,
                         output int lat, output int rst_hi, output int in_bad);
    ifc.vec_input    = vin;
    ifc.vec_expected = vexp;
    ifc.vec_valid    = 1'b1;
    @(posedge clk);
    #1 ifc.vec_valid = 1'b0;
    @(negedge clk);
    lat = 1; rst_hi = 0; in_bad = 0;
    while (!ifc.res_valid && lat < 200) begin
      if (ifc.rst_uut) rst_hi++;
      if (ifc.input_to_uut !== vin) in_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    ifc.res_ready = 1'b1;
    @(posedge clk);
    #1 ifc.res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ifc.rst_uut !== 1'b1) begin bad++; $display("FAIL reset_rst_uut: got %0b want 1", ifc.rst_uut); end
    total++; if (ifc.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %0b want 0", ifc.res_valid); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", ifc.busy); end
    total++; if (ifc.input_to_uut !== 64'h0) begin bad++; $display("FAIL reset_input: got %0h want 0", ifc.input_to_uut); end
    total++; if ({ifc.res_pass, ifc.res_err, ifc.res_timeout} !== 3'b000 || ifc.res_cycles !== 32'd0)
      begin bad++; $display("FAIL reset_res: got flags %0b cycles %0d want 0", {ifc.res_pass, ifc.res_err, ifc.res_timeout}, ifc.res_cycles); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ifc.vec_ready !== 1'b1) begin bad++; $display("FAIL idle_vec_ready: got %0b want 1", ifc.vec_ready); end
  endtask

  task automatic test_pass();
    int lat, rh, ib;
    end_at = 10; err_at = 0;
    run_vec(V1, {24'h0, V1}, lat, rh, ib);
    total++; if (lat != 15) begin bad++; $display("FAIL pass_latency: got %0d want 15", lat); end
    total++; if (rh != 4) begin bad++; $display("FAIL pass_rst_uut_cycles: got %0d want 4", rh); end
    total++; if (ib != 0) begin bad++; $display("FAIL pass_input_stable: got %0d bad cycles want 0", ib); end
    total++; if (ifc.res_pass !== 1'b1) begin bad++; $display("FAIL pass_flag: got %0b want 1", ifc.res_pass); end
    total++; if (ifc.res_cycles !== 32'd10) begin bad++; $display("FAIL pass_cycles: got %0d want 10", ifc.res_cycles); end
    total++; if (ifc.res_err !== 1'b0 || ifc.res_timeout !== 1'b0) begin bad++; $display("FAIL pass_err_to: got %0b%0b want 00", ifc.res_err, ifc.res_timeout); end
    total++; if (ifc.res_output !== {24'h0, V1}) begin bad++; $display("FAIL pass_output: got %0h want %0h", ifc.res_output, {24'h0, V1}); end
    total++; if (ifc.rst_uut !== 1'b1) begin bad++; $display("FAIL pass_report_rst_uut: got %0b want 1", ifc.rst_uut); end
    ack();
    total++; if (ifc.res_valid !== 1'b0 || ifc.vec_ready !== 1'b1) begin bad++; $display("FAIL pass_after_ack: got valid %0b ready %0b want 0 1", ifc.res_valid, ifc.vec_ready); end
  endtask

  task automatic test_mismatch();
    int lat, rh, ib;
    end_at = 10; err_at = 0;
    run_vec(V2, {24'h0, V2} ^ 88'h1, lat, rh, ib);
    total++; if (ifc.res_pass !== 1'b0) begin bad++; $display("FAIL mismatch_pass: got %0b want 0", ifc.res_pass); end
    total++; if (ifc.res_err !== 1'b0 || ifc.res_timeout !== 1'b0) begin bad++; $display("FAIL mismatch_err_to: got %0b%0b want 00", ifc.res_err, ifc.res_timeout); end
    total++; if (ifc.res_output !== {24'h0, V2}) begin bad++; $display("FAIL mismatch_output: got %0h want %0h", ifc.res_output, {24'h0, V2}); end
    total++; if (ifc.res_cycles !== 32'd10) begin bad++; $display("FAIL mismatch_cycles: got %0d want 10", ifc.res_cycles); end
    ack();
  endtask

  task automatic test_timeout();
    int lat, rh, ib;
    end_at = 0; err_at = 0;
    run_vec(V3, {24'h0, V3}, lat, rh, ib);
    total++; if (lat != 25) begin bad++; $display("FAIL timeout_latency: got %0d want 25", lat); end
    total++; if (ifc.res_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %0b want 1", ifc.res_timeout); end
    total++; if (ifc.res_pass !== 1'b0 || ifc.res_err !== 1'b0) begin bad++; $display("FAIL timeout_pass_err: got %0b%0b want 00", ifc.res_pass, ifc.res_err); end
    total++; if (ifc.res_cycles !== 32'd20) begin bad++; $display("FAIL timeout_cycles: got %0d want 20", ifc.res_cycles); end
    total++; if (ifc.rst_uut !== 1'b1) begin bad++; $display("FAIL timeout_rst_uut: got %0b want 1", ifc.rst_uut); end
    ack();
  endtask

  task automatic test_err();
    int lat, rh, ib;
    end_at = 5; err_at = 5;
    run_vec(V1, {24'h0, V1}, lat, rh, ib);
    total++; if (lat != 10) begin bad++; $display("FAIL err_end_latency: got %0d want 10", lat); end
    total++; if (ifc.res_err !== 1'b1 || ifc.res_pass !== 1'b0) begin bad++; $display("FAIL err_end_flags: got err %0b pass %0b want 1 0", ifc.res_err, ifc.res_pass); end
    total++; if (ifc.res_cycles !== 32'd5 || ifc.res_timeout !== 1'b0) begin bad++; $display("FAIL err_end_cycles: got %0d to %0b want 5 0", ifc.res_cycles, ifc.res_timeout); end
    ack();
    end_at = 0; err_at = 7;
    run_vec(V2, {24'h0, V2}, lat, rh, ib);
    total++; if (ifc.res_err !== 1'b1 || ifc.res_pass !== 1'b0 || ifc.res_cycles !== 32'd7)
      begin bad++; $display("FAIL err_only: got err %0b pass %0b cycles %0d want 1 0 7", ifc.res_err, ifc.res_pass, ifc.res_cycles); end
    total++; if (ifc.res_output !== {24'h0, V2}) begin bad++; $display("FAIL err_only_output: got %0h want %0h", ifc.res_output, {24'h0, V2}); end
    ack();
    end_at = 20; err_at = 0;
    run_vec(V3, {24'h0, V3}, lat, rh, ib);
    total++; if (ifc.res_timeout !== 1'b0 || ifc.res_pass !== 1'b1) begin bad++; $display("FAIL end_on_limit: got to %0b pass %0b want 0 1", ifc.res_timeout, ifc.res_pass); end
    total++; if (ifc.res_cycles !== 32'd20 || lat != 25) begin bad++; $display("FAIL end_on_limit_cycles: got %0d lat %0d want 20 25", ifc.res_cycles, lat); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat, rh, ib;
    end_at = 10; err_at = 0;
    run_vec(V1, {24'h0, V1}, lat, rh, ib);
    ifc.vec_input    = V3;
    ifc.vec_expected = {24'h0, V3};
    ifc.vec_valid    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++; if (ifc.res_valid !== 1'b1 || ifc.vec_ready !== 1'b0)
        begin bad++; $display("FAIL hold_handshake[%0d]: got valid %0b ready %0b want 1 0", i, ifc.res_valid, ifc.vec_ready); end
      total++; if (ifc.res_output !== {24'h0, V1} || ifc.res_cycles !== 32'd10 || ifc.res_pass !== 1'b1 || ifc.input_to_uut !== V1)
        begin bad++; $display("FAIL hold_stable[%0d]: got out %0h cycles %0d pass %0b in %0h", i, ifc.res_output, ifc.res_cycles, ifc.res_pass, ifc.input_to_uut); end
    end
    ifc.res_ready = 1'b1;
    @(posedge clk);
    #1 ifc.res_ready = 1'b0;
    @(negedge clk);
    total++; if (ifc.vec_ready !== 1'b1 || ifc.res_valid !== 1'b0 || ifc.input_to_uut !== V1)
      begin bad++; $display("FAIL b2b_idle: got ready %0b valid %0b in %0h want 1 0 %0h", ifc.vec_ready, ifc.res_valid, ifc.input_to_uut, V1); end
    @(posedge clk);
    #1 ifc.vec_valid = 1'b0;
    @(negedge clk);
    total++; if (ifc.busy !== 1'b1 || ifc.input_to_uut !== V3 || ifc.rst_uut !== 1'b1)
      begin bad++; $display("FAIL b2b_accept: got busy %0b in %0h rst_uut %0b want 1 %0h 1", ifc.busy, ifc.input_to_uut, ifc.rst_uut, V3); end
    lat = 0;
    while (!ifc.res_valid && lat < 200) begin @(negedge clk); lat++; end
    total++; if (ifc.res_valid !== 1'b1 || ifc.res_pass !== 1'b1 || ifc.res_cycles !== 32'd10)
      begin bad++; $display("FAIL b2b_second: got valid %0b pass %0b cycles %0d want 1 1 10", ifc.res_valid, ifc.res_pass, ifc.res_cycles); end
    ack();
  endtask

  task automatic test_mid_reset();
    int lat, rh, ib;
    end_at = 10; err_at = 0;
    ifc.vec_input    = V2;
    ifc.vec_expected = {24'h0, V2};
    ifc.vec_valid    = 1'b1;
    @(posedge clk);
    #1 ifc.vec_valid = 1'b0;
    repeat (7) @(negedge clk);
    total++; if (ifc.rst_uut !== 1'b0) begin bad++; $display("FAIL midrst_in_run: got rst_uut %0b want 0", ifc.rst_uut); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (ifc.vec_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.rst_uut !== 1'b1 || ifc.res_valid !== 1'b0)
      begin bad++; $display("FAIL midrst_idle: got ready %0b busy %0b rst_uut %0b valid %0b want 1 0 1 0", ifc.vec_ready, ifc.busy, ifc.rst_uut, ifc.res_valid); end
    total++; if (ifc.input_to_uut !== 64'h0 || ifc.res_cycles !== 32'd0)
      begin bad++; $display("FAIL midrst_cleared: got in %0h cycles %0d want 0 0", ifc.input_to_uut, ifc.res_cycles); end
    run_vec(V1, {24'h0, V1}, lat, rh, ib);
    total++; if (lat != 15 || rh != 4 || ifc.res_pass !== 1'b1 || ifc.res_cycles !== 32'd10)
      begin bad++; $display("FAIL midrst_rerun: got lat %0d rst %0d pass %0b cycles %0d want 15 4 1 10", lat, rh, ifc.res_pass, ifc.res_cycles); end
    ack();
  endtask

  initial begin
    ifc.vec_valid    = 1'b0;
    ifc.vec_input    = '0;
    ifc.vec_expected = '0;
    ifc.res_ready    = 1'b0;
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_err();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
